interrupt_arbiter: RTL and testbench

Interrupt source and arbitration stage directly upstream of the interrupt controller. Holds the machine timer (mtime/mtimecmp) and captures external interrupt lines. Applies global and per-cause masks, selects one winning cause by fixed priority, and issues a single-cycle dispatch pulse with a 3-bit cause. It then locks out further dispatches until the controller's stall handshake completes.

---
 rtl/interrupt_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_interrupt_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// Interrupt source/arbitration stage: machine timer, external edge capture, masking,
// fixed-priority selection and a one-cycle dispatch pulse with stall handshake lockout.
// Optional SYNC_EXT_EN: adds a 2-flop synchronizer on ext_irq ahead of edge detection.
module interrupt_arbiter #(
    parameter int unsigned NUM_EXT = 4,
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               mstatus_mie,
    input  logic [7:0]         mie_mask,
    input  logic               mtimecmp_we,
    input  logic [TIMER_W-1:0] mtimecmp_wdata,
    input  logic               stall_in,
    output logic               interrupt_enable,
    output logic [2:0]         interrupt_cause,
    output logic [7:0]         mip,
    output logic [TIMER_W-1:0] mtime_out
);

    localparam int unsigned CAUSE_W = 3;
    localparam int unsigned MIP_W   = 8;
    localparam int unsigned CNT_W   = 2;

    localparam logic [CAUSE_W-1:0] TIMER_CAUSE = CAUSE_W'(7);
    localparam logic [CNT_W-1:0]   ACK_LAST    = CNT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   mtime_q, mtime_d;
    logic [TIMER_W-1:0]   mtimecmp_q, mtimecmp_d;
    logic [NUM_EXT-1:0]   ext_prev_q;
    logic [NUM_EXT-1:0]   ext_pend_q, ext_pend_d;
    logic                 timer_pend_q;
    logic                 irq_en_q, irq_en_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_EXT-1:0]   ext_smp_c;
    logic [NUM_EXT-1:0]   ext_rise_c;
    logic [NUM_EXT-1:0]   ext_clr_c;
    logic                 timer_hit_c;
    logic [MIP_W-1:0]     pend_c;
    logic [MIP_W-1:0]     elig_c;
    logic [CAUSE_W-1:0]   win_c;

`ifdef SYNC_EXT_EN
    logic [NUM_EXT-1:0]   sync1_q;
    logic [NUM_EXT-1:0]   sync2_q;

    // Two-stage synchronizer for asynchronous external request lines
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (rdy_in) begin
            sync1_q <= ext_irq;
            sync2_q <= sync1_q;
        end
    end

    assign ext_smp_c = sync2_q;
`else
    assign ext_smp_c = ext_irq;
`endif

    assign ext_rise_c  = ext_smp_c & ~ext_prev_q;
    assign timer_hit_c = (mtime_q >= mtimecmp_q);

    // Pending/eligible vectors laid out in cause order; unused causes stay zero
    always_comb begin
        pend_c = MIP_W'(ext_pend_q);
        pend_c[MIP_W-1] = timer_hit_c;
        elig_c = pend_c & mie_mask & {MIP_W{mstatus_mie}};
    end

    // Timer beats every external line; among externals the lowest index wins
    always_comb begin
        win_c = '0;
        for (int i = MIP_W - 2; i >= 0; i--) begin
            if (elig_c[i]) begin
                win_c = CAUSE_W'(i);
            end
        end
        if (elig_c[MIP_W-1]) begin
            win_c = TIMER_CAUSE;
        end
    end

    // Dispatch FSM: next state, pulse, cause latch, ack timeout and pending clear
    always_comb begin
        state_d   = state_q;
        irq_en_d  = 1'b0;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        ext_clr_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|elig_c) begin
                    cause_d  = win_c;
                    irq_en_d = 1'b1;
                    state_d  = ST_FIRE;
                    if (win_c != TIMER_CAUSE) begin
                        ext_clr_c = NUM_EXT'(MIP_W'(1) << win_c);
                    end
                end
            end
            ST_FIRE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (stall_in) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Controller never took the dispatch: give up, pending bit stays consumed
                    if (cnt_q == ACK_LAST) begin
                        state_d = ST_IDLE;
                        cause_d = '0;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!stall_in) begin
                    state_d = ST_IDLE;
                    cause_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = '0;
            end
        endcase
    end

    // Timer and capture next-state; a new edge wins over a same-cycle dispatch clear
    always_comb begin
        mtime_d    = mtime_q + TIMER_W'(1);
        mtimecmp_d = mtimecmp_we ? mtimecmp_wdata : mtimecmp_q;
        ext_pend_d = (ext_pend_q & ~ext_clr_c) | ext_rise_c;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            ext_prev_q   <= '0;
            ext_pend_q   <= '0;
            timer_pend_q <= 1'b0;
            irq_en_q     <= 1'b0;
            cause_q      <= '0;
            cnt_q        <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            ext_prev_q   <= ext_smp_c;
            ext_pend_q   <= ext_pend_d;
            timer_pend_q <= timer_hit_c;
            irq_en_q     <= irq_en_d;
            cause_q      <= cause_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        mip = '0;
        mip[NUM_EXT-1:0] = ext_pend_q;
        mip[MIP_W-1] = timer_pend_q;
    end

    assign interrupt_enable = irq_en_q;
    assign interrupt_cause  = cause_q;
    assign mtime_out        = mtime_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural reference model.
module tb_interrupt_arbiter;

    localparam int NE = 4;
    localparam int TW = 10;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic [NE-1:0] ext_irq;
    logic          mstatus_mie;
    logic [7:0]    mie_mask;
    logic          mtimecmp_we;
    logic [TW-1:0] mtimecmp_wdata;
    logic          stall_in;
    logic          interrupt_enable;
    logic [2:0]    interrupt_cause;
    logic [7:0]    mip;
    logic [TW-1:0] mtime_out;

    always #5 clk_in = ~clk_in;

    interrupt_arbiter #(.NUM_EXT(NE), .TIMER_W(TW)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .ext_irq          (ext_irq),
        .mstatus_mie      (mstatus_mie),
        .mie_mask         (mie_mask),
        .mtimecmp_we      (mtimecmp_we),
        .mtimecmp_wdata   (mtimecmp_wdata),
        .stall_in         (stall_in),
        .interrupt_enable (interrupt_enable),
        .interrupt_cause  (interrupt_cause),
        .mip              (mip),
        .mtime_out        (mtime_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [TW-1:0] m_mtime, m_cmp;
    logic [NE-1:0] m_prev, m_pend, m_s1, m_s2;
    int            m_phase;   // 0 idle, 1 pulse, 2 awaiting ack, 3 handshake
    int            m_age;
    logic [2:0]    m_cause;
    logic          m_pulse;
    logic [7:0]    m_mip;

    // Controller model: raises stall ack_delay cycles after a pulse, for stall_len cycles
    int ack_delay = 0;
    int stall_len = 0;
    int ctl_timer = 0;
    int stall_left = 0;
    int dut_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] e);
        if (e[7]) return 7;
        for (int i = 0; i < 7; i++) if (e[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mtime = '0;
        m_cmp   = '1;
        m_prev  = '0;
        m_pend  = '0;
        m_s1    = '0;
        m_s2    = '0;
        m_phase = 0;
        m_age   = 0;
        m_cause = '0;
        m_pulse = 1'b0;
        m_mip   = '0;
    endtask

    task automatic model_edge();
        logic          tnow;
        logic [7:0]    pend, elig;
        logic [NE-1:0] samp, rise, clr;
        logic          np;
        int            w;
        if (!rdy_in) return;
        tnow = (m_mtime >= m_cmp);
        pend = 8'(m_pend);
        pend[7] = tnow;
        elig = mstatus_mie ? (pend & mie_mask) : 8'h00;
`ifdef SYNC_EXT_EN
        samp = m_s2;
`else
        samp = ext_irq;
`endif
        rise = samp & ~m_prev;
        clr  = '0;
        np   = 1'b0;
        case (m_phase)
            0: if (elig != 8'h00) begin
                w = pick(elig);
                m_cause = 3'(w);
                np = 1'b1;
                m_phase = 1;
                if (w < NE) clr = NE'(1 << w);
            end
            1: begin m_phase = 2; m_age = 0; end
            2: if (stall_in) m_phase = 3;
               else begin
                   m_age++;
                   if (m_age == 3) begin m_phase = 0; m_cause = '0; end
               end
            default: if (!stall_in) begin m_phase = 0; m_cause = '0; end
        endcase
        m_pulse = np;
        m_pend  = (m_pend & ~clr) | rise;
        m_prev  = samp;
        m_s2    = m_s1;
        m_s1    = ext_irq;
        m_mip   = 8'(m_pend);
        m_mip[7] = tnow;
        m_mtime = m_mtime + TW'(1);
        if (mtimecmp_we) m_cmp = mtimecmp_wdata;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_en"},    32'(interrupt_enable), 32'(m_pulse));
        check({tag, "_cause"}, 32'(interrupt_cause),  32'(m_cause));
        check({tag, "_mip"},   32'(mip),              32'(m_mip));
        check({tag, "_mtime"}, 32'(mtime_out),        32'(m_mtime));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs("cyc");
        if (interrupt_enable === 1'b1) dut_pulses++;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall_in = 1'b0;
        end
        if (ctl_timer > 0) begin
            ctl_timer--;
            if (ctl_timer == 0) begin
                stall_in = 1'b1;
                stall_left = stall_len;
            end
        end
        if (m_pulse && ack_delay > 0) ctl_timer = ack_delay;
    endtask

    task automatic wait_pulse(input string tag, input int maxc, output int used);
        used = 0;
        do begin
            step();
            used++;
        end while (interrupt_enable !== 1'b1 && used < maxc);
        if (interrupt_enable !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        @(negedge clk_in);
        stall_in   = 1'b0;
        ctl_timer  = 0;
        stall_left = 0;
        rst_in     = 1'b1;
    endtask

    initial begin
        int   used;
        int   p0;
        logic [TW-1:0] saved;

        rst_in = 1'b0; rdy_in = 1'b1; ext_irq = '0; mstatus_mie = 1'b0;
        mie_mask = 8'h00; mtimecmp_we = 1'b0; mtimecmp_wdata = '0; stall_in = 1'b0;
        model_reset();

        // Reset values, then free-running timer with nothing enabled
        #12;
        check("rst_en", 32'(interrupt_enable), 32'd0);
        check("rst_cause", 32'(interrupt_cause), 32'd0);
        check("rst_mip", 32'(mip), 32'd0);
        check("rst_mtime", 32'(mtime_out), 32'd0);
        do_reset();
        p0 = dut_pulses;
        repeat (100) step();
        check("run100_mtime", 32'(mtime_out), 32'd100);
        check("run100_pulses", 32'(dut_pulses - p0), 32'd0);

        // Timer dispatch with handshake and re-dispatch while still pending
        do_reset();
        mstatus_mie = 1'b1; mie_mask = 8'h80; ack_delay = 1; stall_len = 11;
        repeat (5) step();
        mtimecmp_we = 1'b1; mtimecmp_wdata = TW'(20);
        step();
        mtimecmp_we = 1'b0;
        wait_pulse("tmr1", 60, used);
        check("tmr1_mtime", 32'(mtime_out), 32'd21);
        check("tmr1_cause", 32'(interrupt_cause), 32'd7);
        wait_pulse("tmr2", 40, used);
        check("tmr2_gap", 32'(used), 32'd14);
        check("tmr2_cause", 32'(interrupt_cause), 32'd7);
        mtimecmp_we = 1'b1; mtimecmp_wdata = TW'(1000);
        step();
        mtimecmp_we = 1'b0;
        p0 = dut_pulses;
        repeat (40) step();
        check("tmr_quiet", 32'(dut_pulses - p0), 32'd0);

        // Priority: timer first, then externals in ascending order
        do_reset();
        mstatus_mie = 1'b1; mie_mask = 8'h86; ack_delay = 1; stall_len = 3;
        mtimecmp_we = 1'b1; mtimecmp_wdata = TW'(3);
        step();
        mtimecmp_we = 1'b0;
        step(); step();
        ext_irq = 4'b0110;
        step();
        check("prio_t_en", 32'(interrupt_enable), 32'd1);
        check("prio_t_cause", 32'(interrupt_cause), 32'd7);
        mtimecmp_we = 1'b1; mtimecmp_wdata = TW'(1000);
        step();
        mtimecmp_we = 1'b0;
        wait_pulse("prio1", 50, used);
        check("prio1_cause", 32'(interrupt_cause), 32'd1);
        wait_pulse("prio2", 50, used);
        check("prio2_cause", 32'(interrupt_cause), 32'd2);
        ext_irq = '0;
        repeat (10) step();

        // Masked cause stays pending until enabled
        do_reset();
        mstatus_mie = 1'b1; mie_mask = 8'h00; ack_delay = 1; stall_len = 2;
        ext_irq = 4'b0001;
        p0 = dut_pulses;
        repeat (6) step();
        check("mask_mip0", 32'(mip[0]), 32'd1);
        check("mask_nopulse", 32'(dut_pulses - p0), 32'd0);
        mie_mask = 8'h01;
        wait_pulse("mask", 5, used);
        check("mask_cause", 32'(interrupt_cause), 32'd0);
        check("mask_mip0_clr", 32'(mip[0]), 32'd0);
        ext_irq = '0;
        repeat (8) step();

        // Abandoned dispatch times out and the next cause still goes out
        do_reset();
        mstatus_mie = 1'b1; mie_mask = 8'h0F; ack_delay = 0;
        ext_irq = 4'b0011;
        wait_pulse("to0", 10, used);
        check("to0_cause", 32'(interrupt_cause), 32'd0);
        wait_pulse("to1", 20, used);
        check("to1_gap", 32'(used), 32'd5);
        check("to1_cause", 32'(interrupt_cause), 32'd1);
        ext_irq = '0;
        repeat (8) step();

        // rdy_in low during the handshake freezes everything
        do_reset();
        mstatus_mie = 1'b1; mie_mask = 8'h0F; ack_delay = 1; stall_len = 20;
        ext_irq = 4'b0100;
        wait_pulse("rdy", 10, used);
        repeat (3) step();
        rdy_in = 1'b0;
        saved = m_mtime;
        repeat (10) step();
        check("rdy_frozen_mtime", 32'(mtime_out), 32'(saved));
        check("rdy_frozen_cause", 32'(interrupt_cause), 32'd2);
        rdy_in = 1'b1;
        ext_irq = '0;
        repeat (20) step();
        check("rdy_done_cause", 32'(interrupt_cause), 32'd0);
        ext_irq = 4'b0001;
        wait_pulse("rdy_next", 10, used);
        check("rdy_next_cause", 32'(interrupt_cause), 32'd0);

        // Reset in the middle of a dispatch drops the pulse
        do_reset();
        mstatus_mie = 1'b1; mie_mask = 8'h0F; ext_irq = 4'b1000;
        wait_pulse("midrst", 10, used);
        do_reset();
        check("midrst_en", 32'(interrupt_enable), 32'd0);
        check("midrst_mtime", 32'(mtime_out), 32'd0);

        // Randomized traffic
        ack_delay = 0;
        ext_irq = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            rdy_in      = ($urandom_range(0, 9) != 0);
            mstatus_mie = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mie_mask = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ext_irq = ext_irq ^ NE'($urandom);
            mtimecmp_we    = ($urandom_range(0, 29) == 0);
            mtimecmp_wdata = TW'($urandom);
            stall_in       = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
